// File: rtl/cache_mem_arbiter.sv
// Two-requester refill arbiter in front of a single main-memory read port.
// Alternates between the cache controllers on contention and aborts reads that exceed TIMEOUT wait cycles.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              memDataRdy,
  output logic              memRead,
  output logic [ADDR_W-1:0] memAddr,
  output logic              grant0,
  output logic              grant1,
  output logic              dataRdy0,
  output logic              dataRdy1,
  output logic              memErr,
  output logic [CNT_W-1:0]  missCnt0,
  output logic [CNT_W-1:0]  missCnt1,
  output logic              busy
);

  // Wait counter only has to hold values up to TIMEOUT-1.
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_start;
  logic              w_win;
  logic              w_tmo;
  logic              r_win;
  logic              r_last;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [TO_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]  r_miss0;
  logic [CNT_W-1:0]  r_miss1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; on a tie the requester not served last wins.
  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_win   = r_win;
    w_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_start = 1'b1;
          w_win   = (req0 && req1) ? ~r_last : req1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (memDataRdy) begin
          w_next = S_DONE;
        end else if (r_wcnt == TO_W'(TIMEOUT - 1)) begin
          w_next = S_DONE;
          w_tmo  = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win   <= 1'b0;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wcnt  <= '0;
      r_miss0 <= '0;
      r_miss1 <= '0;
    end else begin
      if (w_start) begin
        r_win  <= w_win;
        r_addr <= w_win ? addr1 : addr0;
        r_wcnt <= '0;
        if (!w_win && (r_miss0 != '1)) begin
          r_miss0 <= r_miss0 + CNT_W'(1);
        end
        if (w_win && (r_miss1 != '1)) begin
          r_miss1 <= r_miss1 + CNT_W'(1);
        end
      end
      if (r_state == S_WAIT) begin
        r_err <= w_tmo;
        if (w_next == S_WAIT) begin
          r_wcnt <= r_wcnt + TO_W'(1);
        end
      end
      if (r_state == S_DONE) begin
        r_last <= r_win;
      end
    end
  end

  // Outputs decode only the state and the registered winner.
  assign memRead  = (r_state == S_WAIT);
  assign busy     = (r_state != S_IDLE);
  assign grant0   = busy && !r_win;
  assign grant1   = busy && r_win;
  assign dataRdy0 = (r_state == S_DONE) && !r_win;
  assign dataRdy1 = (r_state == S_DONE) && r_win;
  assign memErr   = (r_state == S_DONE) && r_err;
  assign memAddr  = r_addr;
  assign missCnt0 = r_miss0;
  assign missCnt1 = r_miss1;

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 15, which sets the block-address width.
REQ-002 The module SHALL have parameter TIMEOUT, default 255, which sets the maximum number of WAIT cycles before an abort.
REQ-003 The module SHALL have parameter CNT_W, default 16, which sets the width of each miss counter.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port req0 / req1, input, 1 bit each: refill request from cache controller 0 / 1.
REQ-007 Port addr0 / addr1, input, ADDR_W bits each: block address of the corresponding request.
REQ-008 Port memDataRdy, input, 1 bit: main memory signals that refill data is valid.
REQ-009 Port memRead, output, 1 bit: read strobe to main memory.
REQ-010 Port memAddr, output, ADDR_W bits: registered address to main memory.
REQ-011 Port grant0 / grant1, output, 1 bit each: the corresponding requester owns the memory port.
REQ-012 Port dataRdy0 / dataRdy1, output, 1 bit each: one-cycle refill-complete pulse to the corresponding requester.
REQ-013 Port memErr, output, 1 bit: one-cycle pulse that accompanies a dataRdy pulse when the transaction timed out.
REQ-014 Port missCnt0 / missCnt1, output, CNT_W bits each: count of grants issued to the corresponding requester.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, WAIT and DONE.
REQ-017 In IDLE with any request high, the FSM SHALL select a winner, register its address into memAddr, and go to WAIT on the next edge.
REQ-018 If only one request is high, that requester SHALL win.
REQ-019 If both requests are high, the winner SHALL be the requester not served last (the lastGrant pointer); after reset the pointer SHALL favour requester 0.
REQ-020 In WAIT, memRead and grantN of the winner SHALL be high, and memAddr SHALL stay stable.
REQ-021 Latency: a request sampled high in IDLE at edge k SHALL make memRead high in the cycle after edge k.
REQ-022 In WAIT, memDataRdy sampled high SHALL move the FSM to DONE.
REQ-023 In DONE, dataRdyN SHALL be high for exactly one cycle, grantN SHALL stay high, memRead SHALL be low, and lastGrant SHALL update to N.
REQ-024 DONE SHALL always be followed by IDLE.
REQ-025 Back-to-back: the earliest next memRead SHALL come two cycles after the dataRdy pulse, with one IDLE cycle between them.
REQ-026 A WAIT-cycle counter SHALL clear on entry to WAIT and increment on each WAIT cycle without memDataRdy.
REQ-027 When the WAIT-cycle counter reaches TIMEOUT, the FSM SHALL go to DONE and assert memErr together with dataRdyN.
REQ-028 If memDataRdy and the timeout condition occur in the same cycle, the data SHALL win and memErr SHALL stay 0.
REQ-029 memDataRdy SHALL be ignored in IDLE and in DONE.
REQ-030 If the requester drops its request during WAIT, the transaction SHALL still complete and the dataRdy pulse SHALL still be issued, because memory reads cannot be aborted.
REQ-031 Requests and address changes of the non-granted requester SHALL have no effect until IDLE.
REQ-032 missCntN SHALL increment by 1 on each IDLE-to-WAIT transition granted to N, and SHALL saturate at all-ones.
REQ-033 At most one of grant0 and grant1 SHALL be high in any cycle, and at most one of dataRdy0 and dataRdy1.
REQ-034 All outputs SHALL be driven from registers or decoded from the state register only, with no combinational path from input to output.

Reset
REQ-035 With rst high, the FSM SHALL enter IDLE immediately, without waiting for a clock edge.
REQ-036 With rst high, memRead, grant0/1, dataRdy0/1, memErr and busy SHALL be 0.
REQ-037 With rst high, memAddr, both miss counters and the WAIT-cycle counter SHALL be 0, and lastGrant SHALL favour requester 0.
REQ-038 Reset asserted during WAIT SHALL drop memRead in the same cycle, and no dataRdy pulse SHALL follow for the aborted transaction.
REQ-039 After rst deasserts, the first edge SHALL sample the requests normally.

Verification
REQ-040 Single request: req0=1, addr0=0x1A2B, memDataRdy high 3 cycles after memRead rises -> memRead=1 with memAddr=0x1A2B for 3 cycles, then dataRdy0 pulses once, missCnt0=1, busy falls.
REQ-041 Contention: req0=req1=1 held through two transactions after reset -> requester 0 is served first and requester 1 second; a third simultaneous request is served to 0; both counters increment correctly.
REQ-042 Timeout: TIMEOUT=4 and memDataRdy never asserted -> dataRdy pulses after 4 WAIT cycles with memErr=1 in the same cycle.
REQ-043 Tie at timeout: memDataRdy asserted exactly on the timeout cycle -> dataRdy pulses with memErr=0.
REQ-044 Reset mid-operation: rst pulsed in the second WAIT cycle -> memRead and grant fall immediately, there is no dataRdy pulse, and the counters read 0.
REQ-045 Saturation: CNT_W=2 with 5 grants to requester 1 -> missCnt1 stays at 3.
